// File: rtl/acc_cmd_sequencer_if.sv
// Command/program interface between the accumulator command sequencer and its environment.
// The master side is the sequencer; the slave side is the loader plus the accumulator.
interface acc_cmd_sequencer_if #(parameter int DEPTH = 8);
  localparam int AW = $clog2(DEPTH);

  logic          load_valid;
  logic [1:0]    load_op;
  logic [3:0]    load_operand;
  logic          load_ready;
  logic          start;
  logic          clear;
  logic [1:0]    operation;
  logic [3:0]    operand;
  logic [3:0]    result;
  logic          running;
  logic          done;
  logic          mismatch;
  logic [AW-1:0] err_index;
  logic [3:0]    expected;

  modport master (
    input  load_valid, load_op, load_operand, start, clear, result,
    output load_ready, operation, operand, running, done, mismatch, err_index, expected
  );

  modport slave (
    output load_valid, load_op, load_operand, start, clear, result,
    input  load_ready, operation, operand, running, done, mismatch, err_index, expected
  );
endinterface

// File: rtl/acc_cmd_sequencer.sv
// Replays a stored program of 4-bit accumulator commands and checks each returned
// result against a shadow copy of the accumulator one cycle after issue.
module acc_cmd_sequencer #(parameter int DEPTH = 8) (
  input logic            clock,
  input logic            reset_L,
  acc_cmd_sequencer_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;
  typedef struct packed {
    logic [1:0] op;
    logic [3:0] opd;
  } cmd_t;

  state_t               state, state_nxt;
  cmd_t [DEPTH-1:0]     mem;
  logic [AW:0]          count;
  logic [AW-1:0]        wptr, rptr, check_idx, err_index;
  logic [3:0]           shadow;
  logic                 check_en, mismatch;
  logic                 accept, go, last_issue, in_rest;

  function automatic logic [3:0] alu(input logic [3:0] a, input logic [1:0] op,
                                     input logic [3:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  assign in_rest    = (state == IDLE) || (state == DONE);
  assign go         = in_rest && bus.start && !bus.clear && (count != '0);
  assign accept     = (state == IDLE) && bus.load_valid && (count < FULL) &&
                      !bus.start && !bus.clear;
  assign last_issue = ({1'b0, rptr} == (count - 1'b1));

  always_ff @(posedge clock) begin
    if (!reset_L) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (bus.clear) state_nxt = IDLE; else if (go) state_nxt = RUN;
      RUN:        if (bus.clear) state_nxt = IDLE; else if (last_issue) state_nxt = CHECK;
      CHECK:      state_nxt = bus.clear ? IDLE : DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Outside RUN the accumulator sees ADD 0 so it holds its value.
  always_comb begin
    bus.operation  = '0;
    bus.operand    = '0;
    bus.load_ready = 1'b0;
    bus.running    = 1'b0;
    bus.done       = 1'b0;
    case (state)
      IDLE:  bus.load_ready = (count < FULL);
      RUN: begin
        bus.operation = mem[rptr].op;
        bus.operand   = mem[rptr].opd;
        bus.running   = 1'b1;
      end
      CHECK: bus.running = 1'b1;
      DONE:  bus.done    = 1'b1;
      default: ;
    endcase
  end

  // Program storage is not reset; count alone decides which entries are valid.
  always_ff @(posedge clock) begin
    if (reset_L && accept) mem[wptr] <= '{op: bus.load_op, opd: bus.load_operand};
  end

  always_ff @(posedge clock) begin
    if (!reset_L) begin
      count     <= '0;
      wptr      <= '0;
      rptr      <= '0;
      shadow    <= '0;
      check_en  <= 1'b0;
      check_idx <= '0;
      mismatch  <= 1'b0;
      err_index <= '0;
    end else begin
      check_en <= 1'b0;
      if (accept) begin
        wptr  <= wptr + 1'b1;
        count <= count + 1'b1;
      end
      if (bus.clear) begin
        count <= '0;
        wptr  <= '0;
        rptr  <= '0;
      end else if (go) begin
        rptr      <= '0;
        shadow    <= bus.result;
        mismatch  <= 1'b0;
        err_index <= '0;
      end else if (state == RUN) begin
        shadow    <= alu(shadow, mem[rptr].op, mem[rptr].opd);
        rptr      <= rptr + 1'b1;
        check_en  <= 1'b1;
        check_idx <= rptr;
      end
      // result lags issue by one cycle, so the shadow is compared a cycle late.
      if (check_en && (bus.result != shadow) && !mismatch) begin
        mismatch  <= 1'b1;
        err_index <= check_idx;
      end
    end
  end

  assign bus.mismatch  = mismatch;
  assign bus.err_index = err_index;
  assign bus.expected  = shadow;
endmodule

// File: doc/acc_cmd_sequencer.md
Name: acc_cmd_sequencer

Overview:
- Initiator side of the 4-bit accumulator command interface (operation[1:0]/operand[3:0] in, result[3:0] out).
- Holds a small program of accumulator commands, replays it into the accumulator one command per cycle, and checks every returned result against an internal shadow model.
- Used for on-chip self-test and scripted demo sequences in front of the accumulator.

Parameters:
- DEPTH, 8, number of program entries; power of two, minimum 2; pointer/count widths are derived from it.

Ports:
- clock  input  1  system clock, all state updates on its rising edge
- reset_L  input  1  synchronous, active-low reset
- load_valid  input  1  program-entry write request
- load_op  input  2  entry opcode: 0 ADD, 1 SUB, 2 OR, 3 XOR
- load_operand  input  4  entry operand
- load_ready  output  1  entry accepted when load_valid && load_ready
- start  input  1  begin replay (pulse)
- clear  input  1  discard program and return to IDLE
- operation  output  2  command opcode to the accumulator
- operand  output  4  command operand to the accumulator
- result  input  4  accumulator state (registered in the accumulator)
- running  output  1  high while commands are being issued or checked
- done  output  1  replay complete, held until the next start or clear
- mismatch  output  1  sticky flag: some checked result differed from the shadow model
- err_index  output  log2(DEPTH)  index of the first mismatching entry
- expected  output  4  shadow-model value

Behaviour:
- Single clock domain. reset_L is synchronous and active-low. Reset takes priority over all other inputs.
- Reset values: state IDLE, count 0, write pointer 0, read pointer 0, shadow 0, operation 0, operand 0, running 0, done 0, mismatch 0, err_index 0, expected 0, load_ready 1.
- Idle command: outside the issue cycles, operation=0 and operand=0 (ADD 0), so the accumulator holds its value.
- The FSM has four states:
  - IDLE: load_ready = (count < DEPTH). An accepted entry is written at the write pointer, and the pointer and count increment. When full, load_ready=0 and load_valid is ignored. start with count>0 goes to RUN, with read pointer 0, shadow <= result, mismatch and err_index cleared. start with count==0 is ignored.
  - RUN: each cycle, operation/operand = mem[read pointer]. The shadow is updated with the same 4-bit function, modulo 16 (ADD/SUB wrap, OR, XOR), and the read pointer increments. After entry count-1 is issued, go to CHECK. load_valid is ignored and load_ready=0.
  - CHECK: a single cycle that performs the final comparison, then goes to DONE.
  - DONE: done=1, running=0, load_ready=0, idle command driven. start replays the program from the current result, as from IDLE. clear goes to IDLE with count and pointers zeroed; the shadow is kept.
- running=1 in RUN and CHECK only.
- Checking latency: the command issued in cycle k is reflected on result in cycle k+1.
  - A registered check_en/check_idx pair compares result against the shadow in the cycle after each issue.
  - This covers the last entry, which is compared during CHECK.
- On the first mismatch, mismatch is set and err_index <= check_idx. Later mismatches do not change err_index.
- expected always equals the shadow register.
- Simultaneous events:
  - clear beats start and load_valid in every state.
  - clear in RUN/CHECK aborts to IDLE immediately and drives the idle command on the next cycle.
  - start during RUN/CHECK is ignored.
  - In IDLE, start and load_valid in the same cycle: start wins and the entry is not written.
- Reset mid-operation behaves exactly as reset from power-up; program contents are don't-care afterwards because count=0.
- The program memory is not cleared by reset or clear; only count gates validity.

Test Plan:
- Reset, then load ADD 5, SUB 2, OR 8, XOR 3, then start with the accumulator at 0 -> operation/operand sequence 0/5, 1/2, 2/8, 3/3 on 4 consecutive cycles; result 5, 3, 11, 8; done=1, mismatch=0, expected=8.
- Wrap: load ADD 15, SUB 9, start with result=8 -> results 7, 14; expected=14; no mismatch.
- Fault: force result=4 in the cycle it should be 3 (entry 1 of the first program) -> mismatch=1, err_index=1; a later forced error at entry 3 leaves err_index=1.
- Full/empty: start with count=0 -> stays IDLE. Load 8 entries -> load_ready drops after the 8th accept, and a 9th load_valid is not written (count stays 8).
- Replay and clear: start in DONE replays from result 8 with the first program -> results 13, 11, 11, 8. clear during the RUN cycle of entry 2 -> IDLE next cycle, operation=0, operand=0, load_ready=1.
- Reset low for 1 cycle mid-RUN -> all outputs return to reset values on the next edge; accumulator commands become ADD 0.
